l1_cache_control: RTL and testbench
===================================

Name: l1_cache_control

Overview:
Sequencing FSM for the 2-way, write-back, write-allocate L1 cache datapath. Decodes processor requests against the datapath hit/dirty/LRU flags, drives every array write enable and mux select, and runs writeback and fill transactions on the L2 interface. Sits between the processor memory port and the L2 cache, beside the L1 datapath. Also keeps saturating hit, miss and writeback counters for performance analysis.

Parameters:
COUNT_WIDTH, 16, width of each performance counter.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
mem_read  in  1  processor read request, held until mem_resp
mem_write  in  1  processor write request, held until mem_resp
hit0, hit1  in  1 each  datapath way hit flags, valid AND tag match
dirty0, dirty1  in  1 each  datapath dirty bits at the current index
lru  in  1  datapath LRU bit; value = victim way (0 or 1)
l2_mem_resp  in  1  L2 transaction complete, 1-cycle pulse
mem_resp  out  1  processor response, 1-cycle pulse
data_in_mux_sel  out  1  0 = L2 line (fill), 1 = merged line (write hit)
l2_mem_address_mux_sel  out  2  00 = processor address, 01 = way0 tag address, 10 = way1 tag address
lru_w  out  1  LRU array write enable
dirty0_w, valid0_w, tag0_w, data0_w  out  1 each  way 0 array write enables
dirty1_w, valid1_w, tag1_w, data1_w  out  1 each  way 1 array write enables
l2_mem_read  out  1  L2 read request, held until l2_mem_resp
l2_mem_write  out  1  L2 write request, held until l2_mem_resp
hit_count, miss_count, wb_count  out  COUNT_WIDTH each  performance counters

Behaviour:
- States: IDLE, WRITEBACK, FILL. Reset state is IDLE.
- Reset values: all outputs are 0, counters are 0, and the retry flag is 0.
- Datapath arrays write synchronously and read combinationally. All outputs are combinational from the state and inputs (Mealy).
- Request (req) = mem_read | mem_write. If both are asserted, the request is treated as a write.
- hit = hit0 | hit1. The hit way is 1 if hit1, else 0. If both flags are set, way 1 wins, matching the datapath read mux.
- Victim way v = lru.

IDLE:
- With no req, all outputs are 0.
- Read hit: mem_resp=1 and lru_w=1 in the same cycle, so hit latency is 0 extra cycles. Next state IDLE.
- Write hit: mem_resp=1, lru_w=1, data_in_mux_sel=1, and data{way}_w=1 plus dirty{way}_w=1 for the hit way only. Next state IDLE.
- Miss with dirty{v}=1: go to WRITEBACK.
- Miss with dirty{v}=0: go to FILL.
- A miss never asserts mem_resp or any write enable in IDLE.

WRITEBACK:
- l2_mem_write=1 and l2_mem_address_mux_sel = 01 (v=0) or 10 (v=1).
- Stay until l2_mem_resp, then go to FILL.

FILL:
- l2_mem_read=1 and l2_mem_address_mux_sel=00.
- On l2_mem_resp, in the same cycle: data_in_mux_sel=0 and data{v}_w, tag{v}_w, valid{v}_w, dirty{v}_w = 1. The dirty datain is mem_write, so a read fill writes clean.
- Then go to IDLE and set the retry flag.
- The retried access hits next cycle and responds normally. A write retry merges the data and sets dirty.
- lru_w is never asserted in WRITEBACK or FILL.

L2 handshake:
- l2_mem_read and l2_mem_write are never asserted together.
- The request is held, with a stable address select, until the l2_mem_resp cycle.
- l2_mem_resp outside WRITEBACK/FILL is ignored.

Request dropped mid-miss:
- The L2 transaction is still completed and the fill is still written.
- Return to IDLE; mem_resp is not asserted for the dropped request.

Reset mid-operation:
- The state returns to IDLE next edge and all outputs drop; the outstanding L2 transaction is abandoned.
- The array contents are not touched.

Counters:
- Each counter increments by 1 and saturates at 2^COUNT_WIDTH-1 (no wrap).
- hit_count increments on an IDLE hit response only when retry=0.
- miss_count increments on the IDLE miss decision cycle.
- wb_count increments on the WRITEBACK cycle that sees l2_mem_resp.
- The retry flag clears on any IDLE cycle with req, or with no req.

Test Plan:
- Read hit, way 1 (hit1=1, mem_read=1) -> same cycle mem_resp=1 and lru_w=1, no data/dirty writes; hit_count 0->1; state stays IDLE.
- Write hit, way 0 (hit0=1, mem_write=1) -> data_in_mux_sel=1, data0_w=dirty0_w=lru_w=mem_resp=1, way 1 enables 0; hit_count +1.
- Clean read miss (lru=1, dirty1=0, L2 resp after 3 cycles) -> l2_mem_read=1 with sel=00 for 4 cycles; data1/tag1/valid1/dirty1_w pulse on the resp cycle; IDLE next; the re-hit gives mem_resp with hit_count unchanged and miss_count=1.
- Dirty write miss (lru=0, dirty0=1) -> WRITEBACK with l2_mem_write=1 and sel=01 until resp, then FILL with l2_mem_read=1 and sel=00, then the retry write-hit merges the data; wb_count=1, miss_count=1, exactly one mem_resp.
- Counter saturation with COUNT_WIDTH=4 -> after 20 read hits hit_count=15; one further miss gives miss_count=1.
- reset_n=0 during FILL while l2_mem_read is high -> next cycle all outputs 0 and state IDLE; counters 0; a subsequent hit responds normally.

Source files
------------

// File: rtl/l1_cache_control_if.sv
// Processor-side and L2-side handshake plus datapath flag/enable bundle
// for the L1 cache controller. The controller uses the slave view; the
// processor/datapath/L2 environment uses the master view.
interface l1_cache_control_if;
    logic       mem_read;
    logic       mem_write;
    logic       hit0;
    logic       hit1;
    logic       dirty0;
    logic       dirty1;
    logic       lru;
    logic       l2_mem_resp;

    logic       mem_resp;
    logic       data_in_mux_sel;
    logic [1:0] l2_mem_address_mux_sel;
    logic       lru_w;
    logic       dirty0_w;
    logic       valid0_w;
    logic       tag0_w;
    logic       data0_w;
    logic       dirty1_w;
    logic       valid1_w;
    logic       tag1_w;
    logic       data1_w;
    logic       l2_mem_read;
    logic       l2_mem_write;

    modport master (
        output mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru, l2_mem_resp,
        input  mem_resp, data_in_mux_sel, l2_mem_address_mux_sel, lru_w,
               dirty0_w, valid0_w, tag0_w, data0_w,
               dirty1_w, valid1_w, tag1_w, data1_w,
               l2_mem_read, l2_mem_write
    );

    modport slave (
        input  mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru, l2_mem_resp,
        output mem_resp, data_in_mux_sel, l2_mem_address_mux_sel, lru_w,
               dirty0_w, valid0_w, tag0_w, data0_w,
               dirty1_w, valid1_w, tag1_w, data1_w,
               l2_mem_read, l2_mem_write
    );
endinterface

// File: rtl/l1_cache_control.sv
// Sequencing FSM for the 2-way write-back, write-allocate L1 cache.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   S_IDLE      | decode request; hits respond in the same cycle
//   S_WRITEBACK | dirty victim line being written to L2
//   S_FILL      | missing line being read from L2 into the victim way
//
// Outputs are Mealy (state + inputs). A completed fill sets r_retry so the
// re-hit that follows is not counted as a fresh hit.
module l1_cache_control #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    l1_cache_control_if.slave      bus,
    output logic [COUNT_WIDTH-1:0] o_hit_count,
    output logic [COUNT_WIDTH-1:0] o_miss_count,
    output logic [COUNT_WIDTH-1:0] o_wb_count
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FILL      = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] C_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] C_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_retry;
    logic [COUNT_WIDTH-1:0] r_hit_count;
    logic [COUNT_WIDTH-1:0] r_miss_count;
    logic [COUNT_WIDTH-1:0] r_wb_count;

    logic w_req;
    logic w_hit;
    logic w_way;
    logic w_victim;
    logic w_victim_dirty;
    logic w_hit_inc;
    logic w_miss_inc;
    logic w_wb_inc;
    logic w_retry_set;

    // Both read and write asserted decodes as a write; way 1 wins a double hit.
    assign w_req          = bus.mem_read | bus.mem_write;
    assign w_hit          = bus.hit0 | bus.hit1;
    assign w_way          = bus.hit1;
    assign w_victim       = bus.lru;
    assign w_victim_dirty = w_victim ? bus.dirty1 : bus.dirty0;

    // State, retry flag and saturating performance counters.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_retry      <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else begin
            r_state <= w_next;
            if (w_retry_set) begin
                r_retry <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_retry <= 1'b0;
            end
            if (w_hit_inc && (r_hit_count != C_MAX)) begin
                r_hit_count <= r_hit_count + C_ONE;
            end
            if (w_miss_inc && (r_miss_count != C_MAX)) begin
                r_miss_count <= r_miss_count + C_ONE;
            end
            if (w_wb_inc && (r_wb_count != C_MAX)) begin
                r_wb_count <= r_wb_count + C_ONE;
            end
        end
    end

    // Next-state decode and every datapath/L2 control output; held low in reset.
    always_comb begin
        w_next                     = r_state;
        w_hit_inc                  = 1'b0;
        w_miss_inc                 = 1'b0;
        w_wb_inc                   = 1'b0;
        w_retry_set                = 1'b0;
        bus.mem_resp               = 1'b0;
        bus.data_in_mux_sel        = 1'b0;
        bus.l2_mem_address_mux_sel = 2'b00;
        bus.lru_w                  = 1'b0;
        bus.dirty0_w               = 1'b0;
        bus.valid0_w               = 1'b0;
        bus.tag0_w                 = 1'b0;
        bus.data0_w                = 1'b0;
        bus.dirty1_w               = 1'b0;
        bus.valid1_w               = 1'b0;
        bus.tag1_w                 = 1'b0;
        bus.data1_w                = 1'b0;
        bus.l2_mem_read            = 1'b0;
        bus.l2_mem_write           = 1'b0;
        if (i_reset_n) begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            bus.mem_resp = 1'b1;
                            bus.lru_w    = 1'b1;
                            w_hit_inc    = !r_retry;
                            if (bus.mem_write) begin
                                bus.data_in_mux_sel = 1'b1;
                                bus.data0_w         = !w_way;
                                bus.dirty0_w        = !w_way;
                                bus.data1_w         = w_way;
                                bus.dirty1_w        = w_way;
                            end
                        end else begin
                            w_miss_inc = 1'b1;
                            w_next     = w_victim_dirty ? S_WRITEBACK : S_FILL;
                        end
                    end
                end
                S_WRITEBACK: begin
                    bus.l2_mem_write           = 1'b1;
                    bus.l2_mem_address_mux_sel = w_victim ? 2'b10 : 2'b01;
                    if (bus.l2_mem_resp) begin
                        w_wb_inc = 1'b1;
                        w_next   = S_FILL;
                    end
                end
                S_FILL: begin
                    bus.l2_mem_read = 1'b1;
                    if (bus.l2_mem_resp) begin
                        bus.data0_w  = !w_victim;
                        bus.tag0_w   = !w_victim;
                        bus.valid0_w = !w_victim;
                        bus.dirty0_w = !w_victim;
                        bus.data1_w  = w_victim;
                        bus.tag1_w   = w_victim;
                        bus.valid1_w = w_victim;
                        bus.dirty1_w = w_victim;
                        w_retry_set  = 1'b1;
                        w_next       = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;
    assign o_wb_count   = r_wb_count;

endmodule

// File: tb/tb_l1_cache_control.sv
// Self-checking bench for l1_cache_control (COUNT_WIDTH=4 to reach saturation).
module tb_l1_cache_control;

    localparam int CW = 4;

    // Expected output word layout:
    // [14] mem_resp [13] data_in_mux_sel [12:11] addr sel [10] lru_w
    // [9:6] dirty0/valid0/tag0/data0 _w  [5:2] dirty1/valid1/tag1/data1 _w
    // [1] l2_mem_read [0] l2_mem_write
    localparam logic [14:0] E_NONE   = 15'b0_0_00_0_0000_0000_00;
    localparam logic [14:0] E_RDHIT  = 15'b1_0_00_1_0000_0000_00;
    localparam logic [14:0] E_WRHIT0 = 15'b1_1_00_1_1001_0000_00;
    localparam logic [14:0] E_WRHIT1 = 15'b1_1_00_1_0000_1001_00;
    localparam logic [14:0] E_FILLW  = 15'b0_0_00_0_0000_0000_10;
    localparam logic [14:0] E_FILL0  = 15'b0_0_00_0_1111_0000_10;
    localparam logic [14:0] E_FILL1  = 15'b0_0_00_0_0000_1111_10;
    localparam logic [14:0] E_WB0    = 15'b0_0_01_0_0000_0000_01;

    logic          clk;
    logic          reset_n;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;
    logic [CW-1:0] wb_count;
    logic [14:0]   act;

    int checks   = 0;
    int failures = 0;
    logic [14:0] exp_q[$];

    l1_cache_control_if bus ();

    l1_cache_control #(.COUNT_WIDTH(CW)) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .bus          (bus.slave),
        .o_hit_count  (hit_count),
        .o_miss_count (miss_count),
        .o_wb_count   (wb_count)
    );

    assign act = {bus.mem_resp, bus.data_in_mux_sel, bus.l2_mem_address_mux_sel, bus.lru_w,
                  bus.dirty0_w, bus.valid0_w, bus.tag0_w, bus.data0_w,
                  bus.dirty1_w, bus.valid1_w, bus.tag1_w, bus.data1_w,
                  bus.l2_mem_read, bus.l2_mem_write};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, h0, h1, d0, d1, lru, l2r;
        logic [14:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[8];

    task automatic set_in(input logic rd, input logic wr, input logic h0, input logic h1,
                          input logic d0, input logic d1, input logic lru, input logic l2r);
        bus.mem_read    = rd;
        bus.mem_write   = wr;
        bus.hit0        = h0;
        bus.hit1        = h1;
        bus.dirty0      = d0;
        bus.dirty1      = d1;
        bus.lru         = lru;
        bus.l2_mem_resp = l2r;
    endtask

    // Push the expectation for the cycle just driven, compare at the falling edge.
    task automatic step(input logic [14:0] e, input string nm);
        logic [14:0] x;
        exp_q.push_back(e);
        @(negedge clk);
        x = exp_q.pop_front();
        checks++;
        if (act !== x) begin
            failures++;
            $display("FAIL %s: outputs got %b expected %b", nm, act, x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string nm, input logic [CW-1:0] a, input logic [CW-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        //           rd wr h0 h1 d0 d1 lru l2r  expected   name
        tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, E_NONE,   "idle_noreq"};
        tbl[1] = '{1, 0, 0, 1, 0, 0, 0, 0, E_RDHIT,  "rd_hit_w1"};
        tbl[2] = '{1, 0, 1, 0, 1, 0, 1, 0, E_RDHIT,  "rd_hit_w0"};
        tbl[3] = '{0, 1, 1, 0, 0, 0, 0, 0, E_WRHIT0, "wr_hit_w0"};
        tbl[4] = '{0, 1, 0, 1, 0, 1, 0, 0, E_WRHIT1, "wr_hit_w1"};
        tbl[5] = '{0, 1, 1, 1, 0, 0, 1, 0, E_WRHIT1, "wr_hit_both"};
        tbl[6] = '{1, 1, 1, 0, 0, 0, 0, 0, E_WRHIT0, "rdwr_hit_w0"};
        tbl[7] = '{0, 0, 0, 0, 0, 1, 1, 1, E_NONE,   "l2resp_idle"};

        reset_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        step(E_NONE, "reset_outputs");
        chk_cnt("reset_hit_count", hit_count, 4'd0);
        chk_cnt("reset_miss_count", miss_count, 4'd0);
        chk_cnt("reset_wb_count", wb_count, 4'd0);

        // Single-cycle IDLE decode table
        for (int i = 0; i < 8; i++) begin
            set_in(tbl[i].rd, tbl[i].wr, tbl[i].h0, tbl[i].h1,
                   tbl[i].d0, tbl[i].d1, tbl[i].lru, tbl[i].l2r);
            step(tbl[i].exp, tbl[i].name);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt("table_hit_count", hit_count, 4'd6);
        chk_cnt("table_miss_count", miss_count, 4'd0);

        // Clean read miss, victim way 1, L2 responds on the 4th FILL cycle
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 1, 0);
        step(E_NONE, "crm_idle_miss");
        for (int i = 0; i < 3; i++) step(E_FILLW, "crm_fill_wait");
        bus.l2_mem_resp = 1'b1;
        step(E_FILL1, "crm_fill_resp");
        set_in(1, 0, 0, 1, 0, 0, 1, 0);
        step(E_RDHIT, "crm_retry_hit");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step(E_NONE, "crm_after");
        chk_cnt("crm_hit_count", hit_count, 4'd0);
        chk_cnt("crm_miss_count", miss_count, 4'd1);
        chk_cnt("crm_wb_count", wb_count, 4'd0);

        // Dirty write miss, victim way 0: WRITEBACK then FILL then merged write
        do_reset();
        set_in(0, 1, 0, 0, 1, 0, 0, 0);
        step(E_NONE, "dwm_idle_miss");
        step(E_WB0, "dwm_wb_wait");
        step(E_WB0, "dwm_wb_wait");
        bus.l2_mem_resp = 1'b1;
        step(E_WB0, "dwm_wb_resp");
        bus.l2_mem_resp = 1'b0;
        step(E_FILLW, "dwm_fill_wait");
        bus.l2_mem_resp = 1'b1;
        step(E_FILL0, "dwm_fill_resp");
        set_in(0, 1, 1, 0, 0, 0, 0, 0);
        step(E_WRHIT0, "dwm_retry_merge");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step(E_NONE, "dwm_after");
        chk_cnt("dwm_wb_count", wb_count, 4'd1);
        chk_cnt("dwm_miss_count", miss_count, 4'd1);
        chk_cnt("dwm_hit_count", hit_count, 4'd0);

        // Hit counter saturation, then a miss whose request is dropped mid-fill
        do_reset();
        set_in(1, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(E_RDHIT, "sat_rd_hit");
        chk_cnt("sat_hit_count", hit_count, 4'd15);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        step(E_NONE, "sat_miss_idle");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step(E_FILLW, "drop_fill_wait");
        bus.l2_mem_resp = 1'b1;
        step(E_FILL0, "drop_fill_resp");
        bus.l2_mem_resp = 1'b0;
        step(E_NONE, "drop_idle_noresp");
        chk_cnt("sat_miss_count", miss_count, 4'd1);
        chk_cnt("sat_hit_hold", hit_count, 4'd15);

        // Reset asserted during FILL
        set_in(1, 0, 0, 0, 0, 0, 1, 0);
        step(E_NONE, "rst_idle_miss");
        step(E_FILLW, "rst_fill_l2rd");
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        step(E_NONE, "rst_after_idle");
        chk_cnt("rst_hit_count", hit_count, 4'd0);
        chk_cnt("rst_miss_count", miss_count, 4'd0);
        chk_cnt("rst_wb_count", wb_count, 4'd0);
        set_in(1, 0, 1, 0, 0, 0, 1, 0);
        step(E_RDHIT, "rst_then_hit");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt("rst_then_hit_count", hit_count, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
